// File: rtl/axis_pixel_unpacker.sv
// axis_pixel_unpacker: splits WORD_WIDTH AXI-stream beats into a serial raster pixel stream.
// Latency: first pixel of a beat is valid the cycle after the beat is accepted; 1 pixel/cycle.
// Backpressure: tready only when empty or when the last lane is leaving (zero-bubble reload).
// Ports:
//   s_axis_aclk, s_axis_areset        clock, async active-high reset
//   s_axis_tdata/tvalid/tlast/tready  packed frame beats in
//   pix_data/pix_valid/pix_ready      serial pixel stream out, first pixel from the beat MSBs
//   pix_x, pix_y                      raster coordinates of pix_data
//   pix_sof, pix_eol, pix_eof         frame/line markers, qualified by pix_valid
//   err_early_tlast, err_missing_tlast  one-cycle pulses, the cycle after the offending beat
module axis_pixel_unpacker #(
  parameter int WORD_WIDTH   = 128,
  parameter int PIXEL_WIDTH  = 8,
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 512
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_areset,
  input  logic [WORD_WIDTH-1:0]           s_axis_tdata,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [PIXEL_WIDTH-1:0]          pix_data,
  output logic                            pix_valid,
  input  logic                            pix_ready,
  output logic [$clog2(IMAGE_WIDTH)-1:0]  pix_x,
  output logic [$clog2(IMAGE_HEIGHT)-1:0] pix_y,
  output logic                            pix_sof,
  output logic                            pix_eol,
  output logic                            pix_eof,
  output logic                            err_early_tlast,
  output logic                            err_missing_tlast
);

  localparam int PPB = WORD_WIDTH / PIXEL_WIDTH;
  localparam int BPF = IMAGE_WIDTH * IMAGE_HEIGHT / PPB;
  localparam int XW  = $clog2(IMAGE_WIDTH);
  localparam int YW  = $clog2(IMAGE_HEIGHT);
  localparam int LW  = $clog2(PPB);
  localparam int BW  = $clog2(BPF);

  localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);
  localparam logic [LW-1:0] L_LAST = LW'(PPB - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BPF - 1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] word_q;
  logic [LW-1:0]         lane_q;
  logic [BW-1:0]         beat_q;
  logic [XW-1:0]         x_q;
  logic [YW-1:0]         y_q;
  logic                  early_q;   // held beat carried a premature tlast
  logic                  run_q;     // low in reset and until the first edge after it
  logic                  err_early_q, err_missing_q;
  logic                  last_lane, accept, consume;

  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    pix_valid     = 1'b0;
    last_lane     = (lane_q == L_LAST);
    case (state_q)
      EMPTY: s_axis_tready = run_q;
      FULL: begin
        pix_valid     = 1'b1;
        // reload in the same cycle the last lane leaves, so a full-rate stream has no bubble
        s_axis_tready = last_lane && pix_ready;
      end
      default: state_d = EMPTY;
    endcase
    accept  = s_axis_tvalid && s_axis_tready;
    consume = pix_valid && pix_ready;
    if (accept) begin
      state_d = FULL;
    end else if (consume && last_lane) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state_q       <= EMPTY;
      run_q         <= 1'b0;
      word_q        <= '0;
      lane_q        <= '0;
      beat_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      early_q       <= 1'b0;
      err_early_q   <= 1'b0;
      err_missing_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= 1'b1;
      err_early_q   <= accept && s_axis_tlast && (beat_q != B_LAST);
      err_missing_q <= accept && !s_axis_tlast && (beat_q == B_LAST);

      if (consume) begin
        // the held word shifts up one lane per pixel, so the output always reads the top slice
        word_q <= word_q << PIXEL_WIDTH;
        lane_q <= last_lane ? '0 : lane_q + 1'b1;
        if (early_q && last_lane) begin
          // a frame cut short by tlast restarts the raster at the next beat
          x_q <= '0;
          y_q <= '0;
        end else if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end

      // a reload only happens as the last lane leaves, so it overrides the shift above
      if (accept) begin
        word_q  <= s_axis_tdata;
        lane_q  <= '0;
        early_q <= s_axis_tlast && (beat_q != B_LAST);
        beat_q  <= (s_axis_tlast || beat_q == B_LAST) ? '0 : beat_q + 1'b1;
      end
    end
  end

  assign pix_data          = word_q[WORD_WIDTH-1 -: PIXEL_WIDTH];
  assign pix_x             = x_q;
  assign pix_y             = y_q;
  assign pix_sof           = pix_valid && (x_q == '0) && (y_q == '0);
  assign pix_eol           = pix_valid && (x_q == X_LAST);
  assign pix_eof           = pix_valid && (((x_q == X_LAST) && (y_q == Y_LAST)) || (early_q && last_lane));
  assign err_early_tlast   = err_early_q;
  assign err_missing_tlast = err_missing_q;

endmodule

// File: tb/tb_axis_pixel_unpacker.sv
// Testbench for axis_pixel_unpacker with a 512x4 image (128 beats per frame) to keep runs short.
module tb_axis_pixel_unpacker;
  localparam int WW  = 128;
  localparam int PW  = 8;
  localparam int IW  = 512;
  localparam int IH  = 4;
  localparam int PPB = WW / PW;
  localparam int BPF = IW * IH / PPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [WW-1:0] tdata = '0;
  logic          tvalid = 1'b0;
  logic          tlast = 1'b0;
  logic          tready;
  logic [PW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic [8:0]    pix_x;
  logic [1:0]    pix_y;
  logic          sof, eol, eof, err_e, err_m;

  axis_pixel_unpacker #(
    .WORD_WIDTH(WW), .PIXEL_WIDTH(PW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)
  ) dut (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(tready),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y),
    .pix_sof(sof), .pix_eol(eol), .pix_eof(eof),
    .err_early_tlast(err_e), .err_missing_tlast(err_m)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // source beats, expected and observed pixel streams
  logic [WW-1:0] src_dat[$];
  bit            src_last[$];
  logic [PW-1:0] e_dat[$];
  int            e_x[$], e_y[$];
  logic [2:0]    e_fl[$];
  logic [PW-1:0] o_dat[$];
  int            o_x[$], o_y[$], o_cyc[$];
  logic [2:0]    o_fl[$];

  int  mx = 0, my = 0, mb = 0;
  int  cyc = 0, acc_cyc = 0;
  int  data_err = 0, stall_err = 0, pulse_err = 0;
  int  n_early = 0, n_miss = 0, n_eol = 0, n_eof = 0;
  int  vld_pct = 100, rdy_pct = 100;
  bit  acc_prev = 0, pend_e = 0, pend_m = 0, stall_prev = 0;
  logic [PW-1:0] s_dat;
  logic [8:0]    s_x;
  logic [1:0]    s_y;
  logic [2:0]    s_fl;

  // reference raster: 16 pixels per beat, MSB byte first
  task automatic model_beat(input logic [WW-1:0] d, input bit last);
    bit early;
    early  = last && (mb != BPF - 1);
    pend_e = early;
    pend_m = !last && (mb == BPF - 1);
    for (int k = 0; k < PPB; k++) begin
      e_dat.push_back(d[WW-1-PW*k -: PW]);
      e_x.push_back(mx);
      e_y.push_back(my);
      e_fl.push_back({(mx == 0 && my == 0), (mx == IW - 1),
                      ((mx == IW - 1 && my == IH - 1) || (early && k == PPB - 1))});
      if (early && k == PPB - 1) begin
        mx = 0; my = 0;
      end else if (mx == IW - 1) begin
        mx = 0; my = (my == IH - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
    mb = (last || mb == BPF - 1) ? 0 : mb + 1;
  endtask

  // one clock: drive at negedge, sample #1 later (values held until the next posedge)
  task automatic step();
    @(negedge clk);
    cyc++;
    if (!tvalid || acc_prev) begin
      if (src_dat.size() > 0 && $urandom_range(99) < vld_pct) begin
        tvalid = 1'b1; tdata = src_dat[0]; tlast = src_last[0];
      end else begin
        tvalid = 1'b0; tlast = 1'b0;
      end
    end
    pix_ready = ($urandom_range(99) < rdy_pct);
    #1;
    if (err_e !== pend_e || err_m !== pend_m) pulse_err++;
    if (err_e) n_early++;
    if (err_m) n_miss++;
    if (stall_prev && (pix_valid !== 1'b1 || pix_data !== s_dat || pix_x !== s_x ||
                       pix_y !== s_y || {sof, eol, eof} !== s_fl)) stall_err++;
    stall_prev = pix_valid && !pix_ready;
    s_dat = pix_data; s_x = pix_x; s_y = pix_y; s_fl = {sof, eol, eof};
    acc_prev = tvalid && tready;
    pend_e = 1'b0; pend_m = 1'b0;
    if (acc_prev) begin
      model_beat(src_dat.pop_front(), src_last.pop_front());
      acc_cyc = cyc;
    end
    if (pix_valid && pix_ready) begin
      o_dat.push_back(pix_data); o_x.push_back(int'(pix_x)); o_y.push_back(int'(pix_y));
      o_fl.push_back({sof, eol, eof}); o_cyc.push_back(cyc);
      if (eol) n_eol++;
      if (eof) n_eof++;
      if (e_dat.size() == 0) begin
        data_err++;
      end else begin
        if (pix_data !== e_dat[0] || int'(pix_x) != e_x[0] || int'(pix_y) != e_y[0] ||
            {sof, eol, eof} !== e_fl[0]) data_err++;
        void'(e_dat.pop_front()); void'(e_x.pop_front());
        void'(e_y.pop_front()); void'(e_fl.pop_front());
      end
    end
  endtask

  task automatic run(input string tag, input int max);
    int n;
    n = 0;
    while ((src_dat.size() > 0 || e_dat.size() > 0 || tvalid) && n < max) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, 64'(n >= max), 0);
  endtask

  task automatic begin_test();
    o_dat.delete(); o_x.delete(); o_y.delete(); o_fl.delete(); o_cyc.delete();
    n_early = 0; n_miss = 0; n_eol = 0; n_eof = 0;
  endtask

  task automatic push_beat(input logic [WW-1:0] d, input bit last);
    src_dat.push_back(d);
    src_last.push_back(last);
  endtask

  function automatic logic [WW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [WW-1:0] w;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_tready", tready, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_data", pix_data, 0);
    check("rst_xy", {pix_x, pix_y}, 0);
    check("rst_markers", {sof, eol, eof, err_e, err_m}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("tready_before_edge", tready, 0);
    @(negedge clk);
    #1;
    check("tready_after_edge", tready, 1);

    // single directed beat, full rate
    begin_test();
    vld_pct = 100; rdy_pct = 100;
    push_beat(128'h000102030405060708090A0B0C0D0E0F, 1'b0);
    run("single", 200);
    check("single_count", o_dat.size(), 16);
    check("single_first", o_dat[0], 8'h00);
    check("single_last", o_dat[15], 8'h0F);
    check("single_latency", o_cyc[0], acc_cyc + 1);
    check("single_span", o_cyc[15] - o_cyc[0], 15);
    check("single_sof", o_fl[0], 3'b100);
    check("single_x15", o_x[15], 15);

    // rest of frame 0 with random tvalid / pix_ready
    begin_test();
    vld_pct = 70; rdy_pct = 60;
    for (int b = 1; b < BPF; b++) push_beat(rnd_word(), b == BPF - 1);
    run("rand", 20000);
    check("rand_count", o_dat.size(), 2032);
    check("rand_eol", n_eol, 4);
    check("rand_eof", n_eof, 1);
    check("rand_last_xy", {o_x[2031], o_y[2031]}, {32'd511, 32'd3});
    check("rand_pulses", n_early + n_miss, 0);
    check("rand_stall", stall_err, 0);

    // full-rate frame with counting bytes
    begin_test();
    vld_pct = 100; rdy_pct = 100;
    for (int b = 0; b < BPF; b++) begin
      for (int k = 0; k < PPB; k++) w[WW-1-PW*k -: PW] = 8'((b * PPB + k) & 8'hFF);
      push_beat(w, b == BPF - 1);
    end
    run("full", 5000);
    check("full_count", o_dat.size(), 2048);
    check("full_no_gaps", o_cyc[2047] - o_cyc[0], 2047);
    check("full_eol", n_eol, 4);
    check("full_eof", n_eof, 1);
    check("full_eol511", {o_x[511], o_fl[511]}, {32'd511, 3'b010});
    check("full_byte300", o_dat[300], 8'd44);
    check("full_last", {o_x[2047], o_y[2047], o_fl[2047]}, {32'd511, 32'd3, 3'b011});
    check("full_pulses", n_early + n_miss, 0);

    // early tlast on beat 31, then one beat of the next frame
    begin_test();
    vld_pct = 80; rdy_pct = 80;
    for (int b = 0; b < 32; b++) push_beat(rnd_word(), b == 31);
    push_beat(rnd_word(), 1'b0);
    run("early", 3000);
    check("early_pulse", n_early, 1);
    check("early_no_missing", n_miss, 0);
    check("early_eof_count", n_eof, 1);
    check("early_eof_pix", {o_x[511], o_y[511], o_fl[511]}, {32'd511, 32'd0, 3'b011});
    check("early_restart", {o_x[512], o_y[512], o_fl[512]}, {32'd0, 32'd0, 3'b100});

    // beats 1..127 without tlast, then the first beat of the next frame
    begin_test();
    vld_pct = 90; rdy_pct = 90;
    for (int b = 0; b < BPF; b++) push_beat(rnd_word(), 1'b0);
    run("missing", 6000);
    check("missing_pulse", n_miss, 1);
    check("missing_no_early", n_early, 0);
    check("missing_eof_count", n_eof, 1);
    check("missing_eof_pix", {o_x[2031], o_y[2031], o_fl[2031]}, {32'd511, 32'd3, 3'b011});
    check("missing_restart", {o_x[2032], o_y[2032], o_fl[2032]}, {32'd0, 32'd0, 3'b100});

    // reset while lane 7 of beat 100 is presented
    begin_test();
    vld_pct = 100; rdy_pct = 100;
    for (int b = 1; b <= 100; b++) push_beat(rnd_word(), 1'b0);
    begin
      int n;
      n = 0;
      while (o_dat.size() < 99 * PPB + 7 && n < 5000) begin
        step();
        n++;
      end
      check("rst_mid_timeout", 64'(n >= 5000), 0);
    end
    @(negedge clk);
    #1;
    check("pre_rst_xy", {pix_x, pix_y}, {9'd71, 2'd3});
    check("pre_rst_data", {pix_valid, pix_data}, {1'b1, e_dat[0]});
    rst = 1'b1;
    #1;
    check("mid_rst_valid", pix_valid, 0);
    check("mid_rst_data", pix_data, 0);
    check("mid_rst_xy", {pix_x, pix_y}, 0);
    src_dat.delete(); src_last.delete();
    e_dat.delete(); e_x.delete(); e_y.delete(); e_fl.delete();
    tvalid = 1'b0; tlast = 1'b0; pix_ready = 1'b0;
    mx = 0; my = 0; mb = 0;
    pend_e = 1'b0; pend_m = 1'b0; acc_prev = 1'b0; stall_prev = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("mid_rst_tready", tready, 0);
    rst = 1'b0;
    begin_test();
    push_beat(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 1'b0);
    run("post_rst", 200);
    check("post_rst_first", {o_dat[0], o_x[0], o_y[0], o_fl[0]}, {8'hA0, 32'd0, 32'd0, 3'b100});
    check("post_rst_last", {o_dat[15], o_x[15]}, {8'hAF, 32'd15});
    check("post_rst_count", o_dat.size(), 16);

    step();
    check("idle_valid", pix_valid, 0);
    check("data_errors", data_err, 0);
    check("stall_errors", stall_err, 0);
    check("pulse_errors", pulse_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
